// File: rtl/dcs_cmd_exec_if.sv
// dcs_cmd_exec_if: command/reply handshake and local register bus bundle
// shared by the DCS command executor and its environment.
interface dcs_cmd_exec_if;
  logic [63:0] dcs_cmd;
  logic        dcs_cmd_valid;
  logic        dcs_cmd_ready;
  logic [15:0] dcs_udp_dst_in;
  logic [15:0] dcs_udp_src_in;
  logic [15:0] reg_addr;
  logic [31:0] reg_wdata;
  logic        reg_we;
  logic        reg_re;
  logic [31:0] reg_rdata;
  logic        reg_ack;
  logic [63:0] dcs_cmd_reply;
  logic        dcs_cmd_update;
  logic [15:0] dcs_udp_dst_port;
  logic [15:0] dcs_udp_src_port;
  logic        udp_reply_stored;
  logic        busy;

  // Environment side: command source, register slave and reply FIFO writer.
  modport master (
    output dcs_cmd, dcs_cmd_valid, dcs_udp_dst_in, dcs_udp_src_in,
    output reg_rdata, reg_ack, udp_reply_stored,
    input  dcs_cmd_ready, reg_addr, reg_wdata, reg_we, reg_re,
    input  dcs_cmd_reply, dcs_cmd_update, dcs_udp_dst_port, dcs_udp_src_port, busy
  );

  // Executor side.
  modport slave (
    input  dcs_cmd, dcs_cmd_valid, dcs_udp_dst_in, dcs_udp_src_in,
    input  reg_rdata, reg_ack, udp_reply_stored,
    output dcs_cmd_ready, reg_addr, reg_wdata, reg_we, reg_re,
    output dcs_cmd_reply, dcs_cmd_update, dcs_udp_dst_port, dcs_udp_src_port, busy
  );
endinterface

// File: rtl/dcs_cmd_exec.sv
// dcs_cmd_exec: executes one DCS command word (write/read/echo) on the SRU
// local register bus and hands the 64-bit reply to the reply FIFO writer.
// One command in flight; a new command is taken only after the writer has
// finished storing the previous reply frame (or the store wait timed out).
// Optional build macro DCS_CMD_EXEC_SEQ_EN: reply[55:48] carries an 8-bit
// reply sequence counter; otherwise that field is zero and no counter exists.
module dcs_cmd_exec #(
  parameter logic [15:0] AckTimeout   = 16'd255,
  parameter logic [7:0]  StoreTimeout = 8'd63
) (
  input  logic          dcs_wr_clk,
  input  logic          reset,
  dcs_cmd_exec_if.slave bus
);

  localparam logic [3:0]  OpWrite     = 4'h1;
  localparam logic [3:0]  OpRead      = 4'h2;
  localparam logic [3:0]  OpEcho      = 4'h3;
  localparam logic [3:0]  StOk        = 4'h0;
  localparam logic [3:0]  StTimeout   = 4'h1;
  localparam logic [3:0]  StBadOp     = 4'h2;
  localparam logic [31:0] TimeoutData = 32'hDEAD_DEAD;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_ACK,
    S_REPLY,
    S_WAIT_RISE,
    S_WAIT_FALL
  } state_t;

  state_t      state_q;
  logic [3:0]  op_q;
  logic [15:0] addr_q;
  logic [31:0] wdata_q;
  logic [15:0] rply_dst_q;
  logic [15:0] rply_src_q;
  logic [15:0] ack_cnt_q;
  logic [7:0]  store_cnt_q;

  logic        ready_q;
  logic        busy_q;
  logic [15:0] reg_addr_q;
  logic [31:0] reg_wdata_q;
  logic        reg_we_q;
  logic        reg_re_q;
  logic [63:0] reply_q;
  logic        update_q;
  logic [15:0] udp_dst_q;
  logic [15:0] udp_src_q;

  logic [7:0]  seq_c;
  logic [3:0]  cmd_op_c;
  logic        cmd_is_bus_c;
  logic        op_is_bus_c;
  logic [11:0] rsvd_unused;

  assign cmd_op_c     = bus.dcs_cmd[63:60];
  assign cmd_is_bus_c = (cmd_op_c == OpWrite) || (cmd_op_c == OpRead);
  assign op_is_bus_c  = (op_q == OpWrite) || (op_q == OpRead);
  assign rsvd_unused  = bus.dcs_cmd[59:48];

  function automatic logic [63:0] make_reply(input logic [3:0]  op,
                                             input logic [3:0]  status,
                                             input logic [7:0]  seq,
                                             input logic [15:0] addr,
                                             input logic [31:0] data);
    return {op, status, seq, addr, data};
  endfunction

`ifdef DCS_CMD_EXEC_SEQ_EN
  logic [7:0] seq_q;

  // Sequence counter advances once per emitted reply, wrapping at 8 bits.
  always_ff @(posedge dcs_wr_clk) begin
    if (reset) begin
      seq_q <= 8'h00;
    end else if (state_q == S_REPLY) begin
      seq_q <= seq_q + 8'd1;
    end
  end

  assign seq_c = seq_q;
`else
  assign seq_c = 8'h00;
`endif

  // Command FSM with registered bus strobes, reply word and handshake outputs.
  always_ff @(posedge dcs_wr_clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      op_q        <= 4'h0;
      addr_q      <= 16'h0000;
      wdata_q     <= 32'h0;
      rply_dst_q  <= 16'h0000;
      rply_src_q  <= 16'h0000;
      ack_cnt_q   <= 16'h0000;
      store_cnt_q <= 8'h00;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
      reg_addr_q  <= 16'h0000;
      reg_wdata_q <= 32'h0;
      reg_we_q    <= 1'b0;
      reg_re_q    <= 1'b0;
      reply_q     <= 64'h0;
      update_q    <= 1'b0;
      udp_dst_q   <= 16'h0000;
      udp_src_q   <= 16'h0000;
    end else begin
      update_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.dcs_cmd_valid && ready_q) begin
            op_q       <= cmd_op_c;
            addr_q     <= bus.dcs_cmd[47:32];
            wdata_q    <= bus.dcs_cmd[31:0];
            // Reply goes back to where the request came from.
            rply_dst_q <= bus.dcs_udp_src_in;
            rply_src_q <= bus.dcs_udp_dst_in;
            if (cmd_is_bus_c) begin
              reg_addr_q  <= bus.dcs_cmd[47:32];
              reg_wdata_q <= bus.dcs_cmd[31:0];
            end
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          if (op_is_bus_c) begin
            reg_we_q  <= (op_q == OpWrite);
            reg_re_q  <= (op_q == OpRead);
            ack_cnt_q <= 16'h0000;
            state_q   <= S_WAIT_ACK;
          end else begin
            reply_q   <= make_reply(op_q, (op_q == OpEcho) ? StOk : StBadOp,
                                    seq_c, addr_q, wdata_q);
            udp_dst_q <= rply_dst_q;
            udp_src_q <= rply_src_q;
            update_q  <= 1'b1;
            state_q   <= S_REPLY;
          end
        end

        S_WAIT_ACK: begin
          // Acknowledge takes priority over a timeout in the same cycle.
          if (bus.reg_ack) begin
            reg_we_q  <= 1'b0;
            reg_re_q  <= 1'b0;
            reply_q   <= make_reply(op_q, StOk, seq_c, addr_q,
                                    (op_q == OpRead) ? bus.reg_rdata : wdata_q);
            udp_dst_q <= rply_dst_q;
            udp_src_q <= rply_src_q;
            update_q  <= 1'b1;
            state_q   <= S_REPLY;
          end else if (ack_cnt_q + 16'd1 == AckTimeout) begin
            reg_we_q  <= 1'b0;
            reg_re_q  <= 1'b0;
            reply_q   <= make_reply(op_q, StTimeout, seq_c, addr_q, TimeoutData);
            udp_dst_q <= rply_dst_q;
            udp_src_q <= rply_src_q;
            update_q  <= 1'b1;
            state_q   <= S_REPLY;
          end else begin
            ack_cnt_q <= ack_cnt_q + 16'd1;
          end
        end

        S_REPLY: begin
          store_cnt_q <= 8'h00;
          state_q     <= S_WAIT_RISE;
        end

        S_WAIT_RISE: begin
          if (bus.udp_reply_stored) begin
            store_cnt_q <= 8'h00;
            state_q     <= S_WAIT_FALL;
          end else if (store_cnt_q + 8'd1 == StoreTimeout) begin
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            store_cnt_q <= store_cnt_q + 8'd1;
          end
        end

        S_WAIT_FALL: begin
          if (!bus.udp_reply_stored || (store_cnt_q + 8'd1 == StoreTimeout)) begin
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            store_cnt_q <= store_cnt_q + 8'd1;
          end
        end

        default: begin
          reg_we_q <= 1'b0;
          reg_re_q <= 1'b0;
          ready_q  <= 1'b1;
          busy_q   <= 1'b0;
          state_q  <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.dcs_cmd_ready    = ready_q;
  assign bus.busy             = busy_q;
  assign bus.reg_addr         = reg_addr_q;
  assign bus.reg_wdata        = reg_wdata_q;
  assign bus.reg_we           = reg_we_q;
  assign bus.reg_re           = reg_re_q;
  assign bus.dcs_cmd_reply    = reply_q;
  assign bus.dcs_cmd_update   = update_q;
  assign bus.dcs_udp_dst_port = udp_dst_q;
  assign bus.dcs_udp_src_port = udp_src_q;

endmodule
